// File: rtl/accum_stop_pkg.sv
// Shared state encoding for the step accumulator and its stop-monitor consumer.
package accum_stop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: the sum clips to all-ones when the carry-out is set.
module sat_add #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    // Widen by one bit so the carry-out shows up as the overflow indication.
    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        ovf  = full[W];
        sum  = full[W] ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/accum_stop_detector.sv
// Step accumulator that stops once the running sum reaches a programmable limit.
module accum_stop_detector
    import accum_stop_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned TICK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_valid,
    input  logic [W-1:0]      step_in,
    input  logic [W-1:0]      limit,
    input  logic              ack,
    output logic [W-1:0]      acc_out,
    output logic [TICK_W-1:0] ticks,
    output logic              busy,
    output logic              stop_flag,
    output logic              stop_pulse,
    output logic              ovf
);

    state_t       state;
    logic [W-1:0] addend;
    logic [W-1:0] acc_nxt;
    logic         add_ovf;

    // A cycle without a valid step contributes zero, so limit=0 still stops.
    always_comb begin
        addend = step_valid ? step_in : '0;
    end

    sat_add #(
        .W (W)
    ) u_sat_add (
        .a   (acc_out),
        .b   (addend),
        .sum (acc_nxt),
        .ovf (add_ovf)
    );

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc_out    <= '0;
            ticks      <= '0;
            busy       <= 1'b0;
            stop_flag  <= 1'b0;
            stop_pulse <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            stop_pulse <= 1'b0;
            // start has priority in every state and always begins a clean run.
            if (start) begin
                state     <= RUN;
                acc_out   <= '0;
                ticks     <= '0;
                ovf       <= 1'b0;
                busy      <= 1'b1;
                stop_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        acc_out <= acc_nxt;
                        ovf     <= ovf | add_ovf;
                        if (step_valid && (ticks != {TICK_W{1'b1}})) begin
                            ticks <= ticks + TICK_W'(1);
                        end
                        if (acc_nxt >= limit) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            stop_flag  <= 1'b1;
                            stop_pulse <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (ack) begin
                            state     <= IDLE;
                            stop_flag <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        stop_flag <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accum_stop_detector.sv
// Scoreboard bench for accum_stop_detector: expectations queued as stimulus is driven.
module tb_accum_stop_detector;

    typedef struct packed {
        logic [7:0]  acc;
        logic [15:0] tk;
        logic        busy;
        logic        flag;
        logic        pulse;
        logic        ovf;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        step_valid;
    logic [7:0]  step_in;
    logic [7:0]  limit;
    logic        ack;
    logic [7:0]  acc_out;
    logic [15:0] ticks;
    logic        busy;
    logic        stop_flag;
    logic        stop_pulse;
    logic        ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t sb[$];

    accum_stop_detector #(
        .W      (8),
        .TICK_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_valid (step_valid),
        .step_in    (step_in),
        .limit      (limit),
        .ack        (ack),
        .acc_out    (acc_out),
        .ticks      (ticks),
        .busy       (busy),
        .stop_flag  (stop_flag),
        .stop_pulse (stop_pulse),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t mk(int a, int t, bit b, bit f, bit p, bit o);
        obs_t r;
        r.acc   = a[7:0];
        r.tk    = t[15:0];
        r.busy  = b;
        r.flag  = f;
        r.pulse = p;
        r.ovf   = o;
        return r;
    endfunction

    function automatic obs_t observe();
        obs_t r;
        r = {acc_out, ticks, busy, stop_flag, stop_pulse, ovf};
        return r;
    endfunction

    function automatic string fmt(obs_t v);
        return $sformatf("acc=%0d ticks=%0d busy=%b flag=%b pulse=%b ovf=%b",
                         v.acc, v.tk, v.busy, v.flag, v.pulse, v.ovf);
    endfunction

    task automatic test_reset();
        obs_t g;
        obs_t e;
        rst = 1'b1; start = 1'b0; step_valid = 1'b0; step_in = '0; limit = '0; ack = 1'b0;
        #12;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        g = observe(); e = sb.pop_front(); n_cmp++;
        if (g !== e) begin
            n_bad++; $display("FAIL reset_state: got %s want %s", fmt(g), fmt(e));
        end
        start = 1'b1;
        tick();
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        g = observe(); e = sb.pop_front(); n_cmp++;
        if (g !== e) begin
            n_bad++; $display("FAIL reset_holds_over_start: got %s want %s", fmt(g), fmt(e));
        end
        start = 1'b0;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        obs_t g;
        obs_t e;
        limit = 8'd100; step_in = 8'd10; start = 1'b1;
        sb.push_back(mk(0, 0, 1, 0, 0, 0));
        tick(); start = 1'b0;
        g = observe(); e = sb.pop_front(); n_cmp++;
        if (g !== e) begin
            n_bad++; $display("FAIL ramp_enter: got %s want %s", fmt(g), fmt(e));
        end
        step_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            sb.push_back(mk(10 * i, i, i < 10, i == 10, i == 10, 0));
            tick();
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL ramp_step%0d: got %s want %s", i, fmt(g), fmt(e));
            end
        end
        step_valid = 1'b0;
        sb.push_back(mk(100, 10, 0, 1, 0, 0));
        tick();
        g = observe(); e = sb.pop_front(); n_cmp++;
        if (g !== e) begin
            n_bad++; $display("FAIL ramp_pulse_width: got %s want %s", fmt(g), fmt(e));
        end
        ack = 1'b1; tick(); ack = 1'b0;
        n_cmp++;
        if ({busy, stop_flag, stop_pulse} !== 3'b000) begin
            n_bad++; $display("FAIL ramp_ack: got busy/flag/pulse=%b%b%b want 000",
                              busy, stop_flag, stop_pulse);
        end
    endtask

    task automatic test_toggle();
        obs_t g;
        obs_t e;
        int   ea = 0;
        int   et = 0;
        bit   done;
        limit = 8'd100; step_in = 8'd10; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 0; c < 19; c++) begin
            step_valid = (c % 2 == 0);
            if (step_valid) begin
                ea += 10;
                et++;
            end
            done = (ea >= 100);
            sb.push_back(mk(ea, et, !done, done, done, 0));
            tick();
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL toggle_cycle%0d: got %s want %s", c, fmt(g), fmt(e));
            end
        end
        for (int c = 0; c < 3; c++) begin
            step_valid = (c % 2 == 0);
            sb.push_back(mk(100, 10, 0, 1, 0, 0));
            tick();
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL toggle_frozen%0d: got %s want %s", c, fmt(g), fmt(e));
            end
        end
        step_valid = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
        n_cmp++;
        if ({busy, stop_flag, stop_pulse} !== 3'b000) begin
            n_bad++; $display("FAIL toggle_ack: got busy/flag/pulse=%b%b%b want 000",
                              busy, stop_flag, stop_pulse);
        end
    endtask

    task automatic test_saturate();
        obs_t g;
        obs_t e;
        limit = 8'd250; step_in = 8'd200; start = 1'b1;
        tick(); start = 1'b0; step_valid = 1'b1;
        sb.push_back(mk(200, 1, 1, 0, 0, 0));
        sb.push_back(mk(255, 2, 0, 1, 1, 1));
        for (int i = 0; i < 2; i++) begin
            tick();
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL saturate_step%0d: got %s want %s", i, fmt(g), fmt(e));
            end
        end
        step_valid = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_limit_zero();
        obs_t g;
        obs_t e;
        limit = 8'd0; step_in = 8'd10; step_valid = 1'b0; start = 1'b1;
        sb.push_back(mk(0, 0, 1, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 1, 1, 0));
        tick(); start = 1'b0;
        g = observe(); e = sb.pop_front(); n_cmp++;
        if (g !== e) begin
            n_bad++; $display("FAIL limit0_enter: got %s want %s", fmt(g), fmt(e));
        end
        tick();
        g = observe(); e = sb.pop_front(); n_cmp++;
        if (g !== e) begin
            n_bad++; $display("FAIL limit0_done: got %s want %s", fmt(g), fmt(e));
        end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_restart();
        obs_t g;
        obs_t e;
        limit = 8'd100; step_in = 8'd10; start = 1'b1;
        tick(); start = 1'b0; step_valid = 1'b1;
        for (int i = 1; i <= 6; i++) sb.push_back(mk(10 * i, i, 1, 0, 0, 0));
        // Restart with a concurrent step: the step must be dropped.
        sb.push_back(mk(0, 0, 1, 0, 0, 0));
        for (int i = 1; i <= 10; i++) sb.push_back(mk(10 * i, i, i < 10, i == 10, i == 10, 0));
        for (int i = 0; i < 17; i++) begin
            start = (i == 6);
            tick();
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL restart_run%0d: got %s want %s", i, fmt(g), fmt(e));
            end
        end
        // start together with ack in DONE, then idle RUN cycles with no stray pulse.
        step_valid = 1'b0; start = 1'b1; ack = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(mk(0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick(); start = 1'b0; ack = 1'b0;
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL restart_done%0d: got %s want %s", i, fmt(g), fmt(e));
            end
        end
        // Saturating run, then restart from DONE must clear the sticky ovf.
        limit = 8'd250; step_in = 8'd200; step_valid = 1'b1;
        sb.push_back(mk(200, 1, 1, 0, 0, 0));
        sb.push_back(mk(255, 2, 0, 1, 1, 1));
        sb.push_back(mk(0, 0, 1, 0, 0, 0));
        sb.push_back(mk(0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            start = (i == 2);
            step_valid = (i < 3);
            ack = (i == 3);
            tick();
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL restart_ovf%0d: got %s want %s", i, fmt(g), fmt(e));
            end
        end
        start = 1'b0; ack = 1'b0; step_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        obs_t g;
        obs_t e;
        limit = 8'd100; step_in = 8'd10; start = 1'b1;
        tick(); start = 1'b0; step_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sb.push_back(mk(10 * i, i, 1, 0, 0, 0));
            tick();
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL midrst_pre%0d: got %s want %s", i, fmt(g), fmt(e));
            end
        end
        #2 rst = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        g = observe(); e = sb.pop_front(); n_cmp++;
        if (g !== e) begin
            n_bad++; $display("FAIL midrst_async: got %s want %s", fmt(g), fmt(e));
        end
        @(posedge clk);
        #3 rst = 1'b0;
        // Back in IDLE: step_valid and ack are ignored, no pulse appears.
        for (int i = 0; i < 2; i++) begin
            ack = (i == 1);
            sb.push_back(mk(0, 0, 0, 0, 0, 0));
            tick();
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL midrst_idle%0d: got %s want %s", i, fmt(g), fmt(e));
            end
        end
        ack = 1'b0; step_valid = 1'b0; start = 1'b1;
        tick(); start = 1'b0; step_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            sb.push_back(mk(10 * i, i, i < 10, i == 10, i == 10, 0));
            tick();
            g = observe(); e = sb.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL midrst_rerun%0d: got %s want %s", i, fmt(g), fmt(e));
            end
        end
        step_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_toggle();
        test_saturate();
        test_limit_zero();
        test_restart();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
